// File: rtl/param_extend_stream.sv
// -----------------------------------------------------------------------------
// param_extend_stream
//   Streaming width extender with an output FIFO. Each accepted IN_W-bit
//   sample is extended to OUT_W bits according to its own mode, stored
//   already extended in a DEPTH-entry FIFO, and delivered on a valid/ready
//   output. Lets narrow sample producers feed the wide datapath while
//   absorbing backpressure from it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (pointers, level, mode_err)
//   in_valid   input sample valid
//   in_ready   FIFO has room (level != DEPTH)
//   in_data    input sample, IN_W bits
//   in_mode    00 zero-ext, 01 sign-ext, 10 left-align, 11 illegal
//   out_valid  head word valid (level != 0)
//   out_ready  consumer accepts head word
//   out_data   extended head word, OUT_W bits (undefined while !out_valid)
//   level      occupied entries, 0..DEPTH
//   mode_err   sticky flag: an illegal-mode sample was accepted
//   clear_err  synchronous clear of mode_err (a same-cycle set wins)
// -----------------------------------------------------------------------------
module param_extend_stream #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 25,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [LVL_W-1:0] level,
  output logic             mode_err,
  input  logic             clear_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'b00,
    MODE_SIGN = 2'b01,
    MODE_LEFT = 2'b10,
    MODE_ILL  = 2'b11
  } mode_e;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OUT_W-1:0] ext_data;
  logic             push;
  logic             pop;
  logic             illegal;

  // Handshake flags come straight from the registered level, so neither
  // ready nor valid has a combinational path from the opposite port.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign illegal   = (mode_e'(in_mode) == MODE_ILL);

  // NOTE: every output of a combinational block gets a default first so a
  // missing case arm can never infer a latch.
  always_comb begin
    ext_data = {{PAD_W{1'b0}}, in_data};
    case (mode_e'(in_mode))
      MODE_SIGN: ext_data = {{PAD_W{in_data[IN_W-1]}}, in_data};
      MODE_LEFT: ext_data = {in_data, {PAD_W{1'b0}}};
      default:   ext_data = {{PAD_W{1'b0}}, in_data};  // zero and illegal
    endcase
  end

  // NOTE: the storage array has no reset; it is only read at rd_ptr while
  // level != 0, so stale contents are never observable and the array can
  // map onto plain RAM/flops without reset routing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ext_data;
  end

  // NOTE: all state registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so the natural PTR_W-bit wrap is modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Set has priority over clear so an error arriving with the clear is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_err <= 1'b0;
    end else if (push && illegal) begin
      mode_err <= 1'b1;
    end else if (clear_err) begin
      mode_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_extend_stream.sv
// -----------------------------------------------------------------------------
// tb_param_extend_stream
//   Directed bench for param_extend_stream (IN_W=2, OUT_W=25, DEPTH=4).
//   Stimulus pushes a hand-computed expected word into exp_q when a sample is
//   accepted; an independent monitor pops and compares whenever the DUT
//   completes an output handshake.
// -----------------------------------------------------------------------------
module tb_param_extend_stream;

  localparam int IN_W  = 2;
  localparam int OUT_W = 25;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [LVL_W-1:0] level;
  logic             mode_err;
  logic             clear_err;

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q [$];

  param_extend_stream #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level),
    .mode_err (mode_err),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, a valid&&ready pair here is the
  // handshake that completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h expected no word at %0t", out_data, $time);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Offer one sample, wait (bounded) for acceptance, then drop in_valid just
  // after the accepting edge.
  task automatic push(input logic [1:0] d, input logic [1:0] m, input logic [OUT_W-1:0] exp);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        accepted = 1'b1;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no accept expected accept at %0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 50 && level != '0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_level", 32'(level), 0);
  endtask

  // Concurrent push/pop table: data, mode, expected word.
  logic [1:0]       cc_d   [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
  logic [1:0]       cc_m   [8] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2};
  logic [OUT_W-1:0] cc_exp [8] = '{25'h0000001, 25'h1FFFFFE, 25'h1800000, 25'h0000000,
                                   25'h0000001, 25'h0000002, 25'h1FFFFFF, 25'h1000000};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    clear_err = 1'b0;
    #12;
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_mode_err", 32'(mode_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1. Extension modes with a free-running consumer.
    out_ready = 1'b1;
    push(2'b11, 2'b01, 25'h1FFFFFF);
    check("t1_sign_visible", 32'(out_valid), 1);
    push(2'b11, 2'b00, 25'h0000003);
    check("t1_zero_visible", 32'(out_valid), 1);
    push(2'b01, 2'b10, 25'h0800000);
    check("t1_left_visible", 32'(out_valid), 1);
    wait_empty();

    // 2. Fill to full, hold a fifth sample, then drain in order.
    out_ready = 1'b0;
    push(2'd1, 2'b00, 25'h0000001);
    push(2'd2, 2'b00, 25'h0000002);
    push(2'd3, 2'b00, 25'h0000003);
    push(2'd0, 2'b00, 25'h0000000);
    check("t2_full_level", 32'(level), 4);
    check("t2_full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 2'd1;
    in_mode  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("t2_held_level", 32'(level), 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_ready_after_pop", 32'(in_ready), 1);
    check("t2_level_after_pop", 32'(level), 3);
    wait_empty();
    check("t2_in_ready_empty", 32'(in_ready), 1);

    // 3. Concurrent push and pop at level 2 across pointer wrap.
    out_ready = 1'b0;
    push(2'd3, 2'b00, 25'h0000003);
    push(2'd1, 2'b10, 25'h0800000);
    check("t3_start_level", 32'(level), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = cc_d[i];
      in_mode  = cc_m[i];
      @(negedge clk);
      if (in_ready) exp_q.push_back(cc_exp[i]);
      check("t3_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      check("t3_level", 32'(level), 2);
    end
    in_valid = 1'b0;
    wait_empty();

    // 4. Illegal mode and sticky error with set-over-clear priority.
    push(2'b10, 2'b11, 25'h0000002);
    check("t4_err_set", 32'(mode_err), 1);
    clear_err = 1'b1;
    push(2'b01, 2'b11, 25'h0000001);
    clear_err = 1'b0;
    check("t4_set_wins", 32'(mode_err), 1);
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
    check("t4_err_cleared", 32'(mode_err), 0);
    wait_empty();

    // 5. Asynchronous reset with three words queued.
    out_ready = 1'b0;
    push(2'd1, 2'b00, 25'h0000001);
    push(2'd2, 2'b00, 25'h0000002);
    push(2'd3, 2'b00, 25'h0000003);
    check("t5_level_before", 32'(level), 3);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_level", 32'(level), 0);
    check("t5_rst_out_valid", 32'(out_valid), 0);
    check("t5_rst_in_ready", 32'(in_ready), 1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(2'b11, 2'b10, 25'h1800000);
    wait_empty();

    // 6. Empty with consumer ready: no underflow.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("t6_out_valid", 32'(out_valid), 0);
      check("t6_level", 32'(level), 0);
    end

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
